fifo_read_packer: RTL and testbench

FIFO_READ_PACKER -- requirements
Module: fifo_read_packer

---
 rtl/fifo_read_pkg.sv | 15 +
 rtl/read_credit_counter.sv | 38 +++
 rtl/fifo_read_packer.sv | 111 +++++++++++
 tb/tb_fifo_read_packer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_pkg.sv
// Shared defaults and types for the FIFO read-side byte packer.
package fifo_read_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned PACK_DEF         = 4;
  localparam int unsigned MAX_INFLIGHT_DEF = 2;

  typedef logic [DATA_WIDTH_DEF*PACK_DEF-1:0] word_t;

  // Width able to count 0..2*pack: both the assembly and the holding register free.
  function automatic int unsigned cap_width(input int unsigned pack);
    return $clog2(2 * pack + 1);
  endfunction

endpackage

// File: rtl/read_credit_counter.sv
// Tracks issued-but-unreturned FIFO reads, gates ren on credit, flags stray returns.
module read_credit_counter
  import fifo_read_pkg::*;
#(
  parameter int unsigned CW           = cap_width(PACK_DEF),
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          empty,
  input  logic          valid_out,
  input  logic [CW-1:0] free,
  output logic          ren,
  output logic          accept,
  output logic [CW-1:0] inflight,
  output logic          proto_err
);

  always_comb begin
    ren    = rst_n && !empty && (inflight < CW'(MAX_INFLIGHT)) && (free > inflight);
    accept = valid_out && (inflight != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (ren && !accept)
        inflight <= inflight + 1'b1;
      else if (!ren && accept)
        inflight <= inflight - 1'b1;
      if (valid_out && (inflight == '0))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Packs FIFO read bytes into PACK-byte words (first byte in the LSB lane) behind a valid/ready holding register.
module fifo_read_packer
  import fifo_read_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned PACK         = PACK_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                       rclk,
  input  logic                       rreset,
  input  logic                       empty,
  output logic                       ren,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       valid_out,
  output logic [DATA_WIDTH*PACK-1:0] word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [15:0]                word_count,
  output logic                       proto_err
);

  localparam int unsigned FCW = $clog2(PACK);
  localparam int unsigned CW  = cap_width(PACK);

  logic [FCW-1:0]                    fcnt;
  logic                              spill;
  logic [PACK-1:0][DATA_WIDTH-1:0]   shreg;
  logic [PACK-1:0][DATA_WIDTH-1:0]   full_word;
  logic [CW-1:0]                     free;
  logic [CW-1:0]                     inflight;
  logic                              accept;
  logic                              hs;
  logic                              hold_free;
  logic                              complete;
  logic                              load_spill;
  logic                              load_byte;

  // A word completed while the holding register was busy parks in the shift
  // register (spill) so the full 2*PACK bytes of buffering can be requested.
  always_comb begin
    hs         = word_valid && word_ready;
    hold_free  = !word_valid || word_ready;
    complete   = accept && (fcnt == FCW'(PACK - 1));
    load_spill = spill && hold_free;
    load_byte  = complete && hold_free;
    full_word  = shreg;
    full_word[PACK-1] = data_out;
    free = '0;
    if (spill) begin
      free = hold_free ? CW'(PACK) : '0;
    end else begin
      free = CW'(PACK) - CW'(fcnt);
      if (hold_free)
        free = free + CW'(PACK);
    end
  end

  read_credit_counter #(
    .CW           (CW),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk       (rclk),
    .rst_n     (rreset),
    .empty     (empty),
    .valid_out (valid_out),
    .free      (free),
    .ren       (ren),
    .accept    (accept),
    .inflight  (inflight),
    .proto_err (proto_err)
  );

  always_ff @(posedge rclk or negedge rreset) begin
    if (!rreset) begin
      fcnt       <= '0;
      spill      <= 1'b0;
      shreg      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      if (hs)
        word_count <= word_count + 16'd1;

      if (load_spill) begin
        word_out   <= shreg;
        word_valid <= 1'b1;
        spill      <= 1'b0;
      end else if (load_byte) begin
        word_out   <= full_word;
        word_valid <= 1'b1;
      end else if (hs) begin
        word_valid <= 1'b0;
      end

      if (accept) begin
        if (complete) begin
          fcnt <= '0;
          if (!hold_free) begin
            shreg <= full_word;
            spill <= 1'b1;
          end
        end else begin
          shreg[fcnt] <= data_out;
          fcnt        <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Self-checking bench: FIFO read-port model with variable latency, byte scoreboard on the word output.
module tb_fifo_read_packer;
  import fifo_read_pkg::*;

  localparam int unsigned DW = DATA_WIDTH_DEF;
  localparam int unsigned PK = PACK_DEF;
  localparam int unsigned MI = MAX_INFLIGHT_DEF;

  typedef struct {
    logic [DW-1:0] b;
    int unsigned   due;
  } rtn_t;

  logic              rclk;
  logic              rreset;
  logic              empty;
  logic              ren;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic [DW*PK-1:0]  word_out;
  logic              word_valid;
  logic              word_ready;
  logic [15:0]       word_count;
  logic              proto_err;

  fifo_read_packer #(
    .DATA_WIDTH   (DW),
    .PACK         (PK),
    .MAX_INFLIGHT (MI)
  ) u_dut (
    .rclk       (rclk),
    .rreset     (rreset),
    .empty      (empty),
    .ren        (ren),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_count (word_count),
    .proto_err  (proto_err)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [DW-1:0] src[$];
  logic [DW-1:0] expq[$];
  rtn_t         rtn[$];
  int unsigned  cyc = 0;
  int unsigned  last_due = 0;
  int           hs_count = 0;
  int           req_total = 0;
  int           vcycles = 0;
  int unsigned  vo_cyc = 0;
  int unsigned  rise_cyc = 0;
  int           ready_mode = 1;
  int           lat_mode = 0;
  logic         hold_empty = 1'b0;
  logic         inject = 1'b0;
  word_t        last_word = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge rclk);
      #3;
    end
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(posedge rclk);
      #3;
      n++;
    end
    check_eq("wait_words", 64'(hs_count), 64'(target));
  endtask

  task automatic push_bytes(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) src.push_back(first + DW'(i));
  endtask

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // FIFO read-port model plus output monitor; acts at the falling edge for the next rising edge.
  initial begin
    logic          prev_stall = 1'b0;
    logic          prev_wv = 1'b0;
    logic [DW*PK-1:0] prev_word = '0;
    forever begin
      @(negedge rclk);
      cyc++;
      case (ready_mode)
        0:       word_ready = 1'b0;
        1:       word_ready = 1'b1;
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
      empty     = (src.size() == 0) || hold_empty;
      valid_out = 1'b0;
      data_out  = '0;
      if (rreset) begin
        if (inject) begin
          valid_out = 1'b1;
          data_out  = 8'hEE;
          inject    = 1'b0;
        end else if (rtn.size() > 0 && rtn[0].due <= cyc) begin
          rtn_t r;
          r = rtn.pop_front();
          valid_out = 1'b1;
          data_out  = r.b;
          expq.push_back(r.b);
          vo_cyc = cyc;
        end
      end
      #1;
      if (rreset) begin
        if (ren) begin
          logic [DW-1:0] b;
          int unsigned   d;
          check_eq("ren_while_empty", 64'(empty), 64'(0));
          b = '0;
          if (src.size() > 0) b = src.pop_front();
          d = cyc + (lat_mode != 0 ? $urandom_range(1, 3) : 1);
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          rtn.push_back('{b: b, due: d});
          req_total++;
          check_eq("tb_inflight_max", 64'(rtn.size() <= MI), 64'(1));
        end
        check_eq("dut_inflight_max", 64'(u_dut.u_credit.inflight <= MI), 64'(1));
        if (word_valid) vcycles++;
        if (word_valid && !prev_wv) rise_cyc = cyc;
        if (prev_stall) begin
          check_eq("hold_valid", 64'(word_valid), 64'(1));
          check_eq("hold_data", 64'(word_out), 64'(prev_word));
        end
        if (word_valid && word_ready) begin
          if (expq.size() < PK) begin
            check_eq("word_underrun", 64'(expq.size()), 64'(PK));
          end else begin
            word_t expw;
            for (int i = 0; i < PK; i++) expw[i*DW +: DW] = expq.pop_front();
            check_eq("word_data", 64'(word_out), 64'(expw));
          end
          last_word = word_out;
          hs_count++;
        end
        prev_stall = word_valid && !word_ready;
        prev_wv    = word_valid;
        prev_word  = word_out;
      end else begin
        prev_stall = 1'b0;
        prev_wv    = 1'b0;
      end
    end
  end

  initial begin
    int req_base;
    rreset = 1'b0;
    empty = 1'b1;
    valid_out = 1'b0;
    data_out = '0;
    word_ready = 1'b0;
    wait_cycles(3);
    check_eq("rst_ren", 64'(ren), 64'(0));
    check_eq("rst_word_valid", 64'(word_valid), 64'(0));
    check_eq("rst_word_out", 64'(word_out), 64'(0));
    check_eq("rst_word_count", 64'(word_count), 64'(0));
    check_eq("rst_proto_err", 64'(proto_err), 64'(0));
    rreset = 1'b1;
    wait_cycles(2);

    // single word, immediate consumer
    ready_mode = 1;
    vcycles = 0;
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
    wait_count(1, 40);
    wait_cycles(3);
    check_eq("t1_word", 64'(last_word), 64'h44332211);
    check_eq("t1_count", 64'(word_count), 64'd1);
    check_eq("t1_valid_cycles", 64'(vcycles), 64'd1);
    check_eq("t1_latency", 64'(rise_cyc - vo_cyc), 64'd1);

    // backpressure: consumer stalled while 12 bytes are available
    ready_mode = 0;
    req_base = req_total;
    push_bytes(8'hA0, 12);
    wait_cycles(20);
    check_eq("t2_requested", 64'(req_total - req_base), 64'd8);
    check_eq("t2_src_left", 64'(src.size()), 64'd4);
    check_eq("t2_ren_stalled", 64'(ren), 64'(0));
    check_eq("t2_valid", 64'(word_valid), 64'(1));
    check_eq("t2_word_held", 64'(word_out), 64'hA3A2A1A0);
    ready_mode = 1;
    wait_count(4, 80);
    wait_cycles(3);
    check_eq("t2_count", 64'(word_count), 64'd4);
    check_eq("t2_last_word", 64'(last_word), 64'hABAAA9A8);
    check_eq("t2_src_drained", 64'(src.size()), 64'd0);

    // partial word held across an empty FIFO
    push_bytes(8'h51, 6);
    wait_cycles(25);
    check_eq("t3_count", 64'(word_count), 64'd5);
    check_eq("t3_word", 64'(last_word), 64'h54535251);
    check_eq("t3_fcnt", 64'(u_dut.fcnt), 64'd2);
    check_eq("t3_ren", 64'(ren), 64'(0));
    check_eq("t3_no_padded", 64'(word_valid), 64'(0));
    push_bytes(8'h57, 2);
    wait_count(6, 40);
    wait_cycles(2);
    check_eq("t3_word2", 64'(last_word), 64'h58575655);

    // stray return with nothing in flight
    check_eq("t4_proto_before", 64'(proto_err), 64'(0));
    inject = 1'b1;
    wait_cycles(3);
    check_eq("t4_proto_set", 64'(proto_err), 64'(1));
    check_eq("t4_inflight", 64'(u_dut.u_credit.inflight), 64'd0);
    check_eq("t4_fcnt", 64'(u_dut.fcnt), 64'd0);
    check_eq("t4_word_valid", 64'(word_valid), 64'(0));
    check_eq("t4_count", 64'(word_count), 64'd6);
    wait_cycles(5);
    check_eq("t4_proto_sticky", 64'(proto_err), 64'(1));

    // reset in the middle of a word
    push_bytes(8'h61, 3);
    wait_cycles(15);
    check_eq("t5_fcnt_pre", 64'(u_dut.fcnt), 64'd3);
    rreset = 1'b0;
    #1;
    check_eq("t5_ren", 64'(ren), 64'(0));
    check_eq("t5_word_valid", 64'(word_valid), 64'(0));
    check_eq("t5_word_out", 64'(word_out), 64'(0));
    check_eq("t5_word_count", 64'(word_count), 64'(0));
    check_eq("t5_proto_err", 64'(proto_err), 64'(0));
    check_eq("t5_fcnt", 64'(u_dut.fcnt), 64'd0);
    check_eq("t5_inflight", 64'(u_dut.u_credit.inflight), 64'd0);
    src.delete();
    expq.delete();
    rtn.delete();
    hs_count = 0;
    last_due = 0;
    wait_cycles(2);
    rreset = 1'b1;
    wait_cycles(1);
    push_bytes(8'h71, 4);
    wait_count(1, 40);
    wait_cycles(2);
    check_eq("t5_clean_word", 64'(last_word), 64'h74737271);
    check_eq("t5_count", 64'(word_count), 64'd1);

    // random latency and random consumer readiness
    ready_mode = 2;
    lat_mode = 1;
    for (int i = 0; i < 200; i++) src.push_back(DW'($urandom_range(0, 255)));
    wait_count(51, 4000);
    ready_mode = 1;
    wait_cycles(10);
    check_eq("t6_src_empty", 64'(src.size()), 64'd0);
    check_eq("t6_exp_empty", 64'(expq.size()), 64'd0);
    check_eq("t6_rtn_empty", 64'(rtn.size()), 64'd0);
    check_eq("t6_count", 64'(word_count), 64'd51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
